demux1x2_32bit_buf: RTL and testbench

- Buffered 1-to-2 demultiplexer for the 32-bit datapath; the inverse of the 2-to-1 select mux.
- Accepts one 32-bit word per cycle, with a per-word select, over a valid/ready handshake.
- Stores up to two words in order and steers each word to destination port 0 or port 1.
- Used where one producer (e.g. store data) must feed one of two sinks (e.g. data memory vs memory-mapped I/O) that can stall independently.

---
 rtl/demux1x2_32bit_buf.sv | 91 +++++++++
 tb/tb_demux1x2_32bit_buf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: 2-entry in-order FIFO of {sel, data},
// head word steered to port 0 or port 1 with per-port delivery counters.
module demux1x2_32bit_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mem [2];
    entry_t           head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic             not_empty;
    logic             push;
    logic             pop0;
    logic             pop1;
    logic             pop;

    // All handshake outputs decode from registered state only
    assign head       = mem[rd_ptr];
    assign not_empty  = (occ_q != 2'd0);
    assign in_ready   = (occ_q != 2'd2) && rst_n;
    assign out0_valid = not_empty & ~head.sel;
    assign out1_valid = not_empty &  head.sel;
    assign out0_data  = head.data & {WIDTH{out0_valid}};
    assign out1_data  = head.data & {WIDTH{out1_valid}};
    assign occupancy  = occ_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

    assign push = in_valid & in_ready;
    assign pop0 = out0_valid & out0_ready;
    assign pop1 = out1_valid & out1_ready;
    assign pop  = pop0 | pop1;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointers, occupancy and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ_q <= occ_d;
            if (pop0) cnt0_q <= cnt0_q + CNT_W'(1);
            if (pop1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    // Storage needs no reset: occupancy 0 masks any stale contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sel: in_sel, data: in_data};
    end

endmodule

// File: tb/tb_demux1x2_32bit_buf.sv
// Randomized and directed bench for demux1x2_32bit_buf against a queue-based model.
module tb_demux1x2_32bit_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [1:0]  occupancy;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    demux1x2_32bit_buf #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .occupancy(occupancy), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   mc0;
    int   mc1;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic        v0;
        logic        v1;
        logic [31:0] hd;
        v0 = 1'b0;
        v1 = 1'b0;
        hd = '0;
        if (q.size() > 0) begin
            v0 = ~q[0].sel;
            v1 = q[0].sel;
            hd = q[0].data;
        end
        check("in_ready",   32'(in_ready),   32'(rst_n && q.size() < 2));
        check("out0_valid", 32'(out0_valid), 32'(v0));
        check("out1_valid", 32'(out1_valid), 32'(v1));
        check("out0_data",  out0_data,       v0 ? hd : 32'h0);
        check("out1_data",  out1_data,       v1 ? hd : 32'h0);
        check("occupancy",  32'(occupancy),  32'(q.size()));
        check("cnt0",       32'(cnt0),       32'(mc0));
        check("cnt1",       32'(cnt1),       32'(mc1));
    endtask

    // One clock cycle: drive, check, then advance the model at the edge
    task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        compare_outputs();
        do_push = v && rst_n && (q.size() < 2);
        do_pop  = (q.size() > 0) && (q[0].sel ? r1 : r0);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mc0 = 0;
            mc1 = 0;
        end else begin
            if (do_pop) begin
                e = q.pop_front();
                if (e.sel) mc1 = (mc1 + 1) % 65536;
                else       mc0 = (mc0 + 1) % 65536;
            end
            if (do_push) q.push_back('{sel: s, data: d});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mc0 = 0;
        mc1 = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Reset then idle
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Basic routing
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("basic_out0", out0_data, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        check("basic_out1", out1_data, 32'h1234_5678);
        check("basic_out0_idle", out0_data, 32'h0);
        drain();
        check("basic_cnt0", 32'(cnt0), 32'd1);
        check("basic_cnt1", 32'(cnt1), 32'd1);

        // Back-pressure and full
        cycle(1'b1, 1'b0, 32'h1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
        check("full_occ", 32'(occupancy), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_hold", out0_data, 32'h1);
        drain();
        check("full_cnt0", 32'(cnt0), 32'd3);

        // Head-of-line blocking
        cycle(1'b1, 1'b0, 32'hA, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'hB, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("hol_out1_valid", 32'(out1_valid), 32'd0);
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("hol_out1_data", out1_data, 32'hB);
        drain();

        // Throughput: alternating stream, readies high
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'(i % 2), $urandom, 1'b1, 1'b1);
            if (i > 0) check("tput_occ", 32'(occupancy), 32'd1);
        end
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        drain();

        // Counter wrap on port 0
        while (mc0 + q.size() < 65535) cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
        drain();
        check("wrap_pre", 32'(cnt0), 32'h0000_FFFF);
        cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
        drain();
        check("wrap_post", 32'(cnt0), 32'h0);

        // Asynchronous reset while full
        cycle(1'b1, 1'b0, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h66, 1'b0, 1'b0);
        check("pre_rst_occ", 32'(occupancy), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_v0", 32'(out0_valid), 32'd0);
        check("arst_v1", 32'(out1_valid), 32'd0);
        check("arst_d0", out0_data, 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        mc0 = 0;
        mc1 = 0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            check("post_rst_cnt0", 32'(cnt0), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
